slt_seq: RTL and testbench

Parametrised, multi-cycle set-on-compare unit for the execute stage. It compares two WIDTH-bit operands CHUNK bits per cycle, LSB chunk first, carrying a borrow between chunks. It produces a zero-extended 0/1 result for signed less-than, unsigned less-than, equality or signed greater-or-equal. Operands are accepted, and results returned, through valid/ready handshakes so the unit can stall the pipeline while it iterates.

---
 rtl/slt_seq.sv | 122 ++++++++++++
 tb/tb_slt_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/slt_seq.sv
// Multi-cycle set-on-compare unit: compares two WIDTH-bit operands CHUNK bits per cycle,
// LSB chunk first, and returns a zero-extended SLT/SLTU/SEQ/SGE flag over valid/ready.
module slt_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             busy
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [1:0]        op_q;
  logic [IdxW-1:0]   idx_q;
  logic              borrow_q;
  logic              eq_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [OUT_W-1:0]  result_q;

  logic [WIDTH-1:0]  a_sh, b_sh;
  logic [CHUNK-1:0]  ca, cb;
  logic [CHUNK:0]    d;
  logic              last;
  logic              eq_nxt;
  logic              ovf, lts, ltu;
  logic              flag;

  always_comb begin
    a_sh   = a_q >> (idx_q * CHUNK);
    b_sh   = b_q >> (idx_q * CHUNK);
    ca     = a_sh[CHUNK-1:0];
    cb     = b_sh[CHUNK-1:0];
    d      = {1'b0, ca} - {1'b0, cb} - {{CHUNK{1'b0}}, borrow_q};
    last   = (idx_q == IdxW'(N - 1));
    // Chunks are equal exactly when the low CHUNK bits of d equal -borrow.
    eq_nxt = eq_q & (d[CHUNK-1:0] == {CHUNK{borrow_q}});
    ltu    = d[CHUNK];
    ovf    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d[CHUNK-1]);
    lts    = d[CHUNK-1] ^ ovf;
  end

  always_comb begin
    flag = 1'b0;
    unique case (op_q)
      2'b00:   flag = lts;
      2'b01:   flag = ltu;
      2'b10:   flag = eq_nxt;
      2'b11:   flag = ~lts;
      default: flag = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      eq_q        <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            eq_q     <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          borrow_q <= d[CHUNK];
          eq_q     <= eq_nxt;
          idx_q    <= idx_q + IdxW'(1);
          if (last) begin
            result_q    <= OUT_W'(flag);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_slt_seq.sv
// Self-checking bench for slt_seq: directed corner cases on the default configuration and
// randomised operations on three configurations against an arithmetic reference model.
module tb_slt_seq;

  localparam int NCFG = 3;
  localparam int NRAND = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [NCFG];
  logic        in_ready  [NCFG];
  logic [31:0] a_s       [NCFG];
  logic [31:0] b_s       [NCFG];
  logic [1:0]  op_s      [NCFG];
  logic        out_valid [NCFG];
  logic        out_ready [NCFG];
  logic [31:0] result    [NCFG];
  logic        busy      [NCFG];

  int wid [NCFG] = '{32, 32, 16};
  int nch [NCFG] = '{4, 1, 4};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  slt_seq #(.WIDTH(32), .CHUNK(8), .OUT_W(32)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_s[0]), .b(b_s[0]), .op(op_s[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0])
  );

  slt_seq #(.WIDTH(32), .CHUNK(32), .OUT_W(32)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_s[1]), .b(b_s[1]), .op(op_s[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1])
  );

  slt_seq #(.WIDTH(16), .CHUNK(4), .OUT_W(32)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_s[2][15:0]), .b(b_s[2][15:0]), .op(op_s[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .result(result[2]), .busy(busy[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as w-bit two's-complement / unsigned integers.
  function automatic logic model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic [1:0] opv, input int w);
    longint sa, sb;
    logic   lts;
    sa  = longint'({32'd0, av} << (64 - w)) >>> (64 - w);
    sb  = longint'({32'd0, bv} << (64 - w)) >>> (64 - w);
    lts = (sa < sb);
    case (opv)
      2'b00:   return lts;
      2'b01:   return (av < bv);
      2'b10:   return (av == bv);
      default: return !lts;
    endcase
  endfunction

  // Accept a request on the next edge, then wait (bounded) for out_valid.
  task automatic issue(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic [1:0] opv, output int lat);
    in_valid[k] = 1'b1;
    a_s[k]      = av;
    b_s[k]      = bv;
    op_s[k]     = opv;
    @(negedge clk);
    in_valid[k] = 1'b0;
    a_s[k]      = $urandom;
    b_s[k]      = $urandom;
    op_s[k]     = 2'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input int k);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic [1:0] opv, output logic [31:0] res, output int lat);
    issue(k, av, bv, opv, lat);
    res = result[k];
    drain(k);
  endtask

  task automatic directed(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [1:0] opv, input logic [31:0] exp);
    logic [31:0] res;
    int          lat;
    do_op(0, av, bv, opv, res, lat);
    chk({tag, ".result"}, 64'(res), 64'(exp));
    chk({tag, ".latency"}, 64'(lat), 64'd4);
  endtask

  task automatic rand_run(input int k);
    logic [31:0] mask, msb, av, bv, res;
    logic [31:0] corner [5];
    logic [1:0]  opv;
    int          lat;
    mask   = (wid[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[k]) - 32'd1);
    msb    = 32'd1 << (wid[k] - 1);
    corner = '{32'd0, 32'd1, msb, msb - 32'd1, mask};
    for (int i = 0; i < NRAND; i++) begin
      av  = $urandom & mask;
      bv  = $urandom & mask;
      opv = 2'($urandom);
      if ($urandom_range(0, 3) == 0) bv = av;
      if ($urandom_range(0, 5) == 0) av = corner[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) bv = corner[$urandom_range(0, 4)];
      do_op(k, av, bv, opv, res, lat);
      chk($sformatf("cfg%0d.rand a=%0h b=%0h op=%0d", k, av, bv, opv),
          64'(res), 64'(model(av, bv, opv, wid[k])));
      chk($sformatf("cfg%0d.rand.latency", k), 64'(lat), 64'(nch[k]));
    end
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] res;
    int          lat;
    logic        stray;
    for (int k = 0; k < NCFG; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      a_s[k]       = '0;
      b_s[k]       = '0;
      op_s[k]      = '0;
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("reset.in_ready", 64'(in_ready[0]), 64'd1);
    chk("reset.out_valid", 64'(out_valid[0]), 64'd0);
    chk("reset.busy", 64'(busy[0]), 64'd0);
    chk("reset.result", 64'(result[0]), 64'd0);

    directed("slt_neg1_1", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'd1);
    directed("sltu_max_1", 32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 32'd0);
    directed("slt_minneg_1", 32'h8000_0000, 32'h0000_0001, 2'b00, 32'd1);
    directed("slt_maxpos_minneg", 32'h7FFF_FFFF, 32'h8000_0000, 2'b00, 32'd0);
    directed("sge_minneg_1", 32'h8000_0000, 32'h0000_0001, 2'b11, 32'd0);
    directed("sge_maxpos_minneg", 32'h7FFF_FFFF, 32'h8000_0000, 2'b11, 32'd1);
    directed("seq_equal", 32'h1234_5678, 32'h1234_5678, 2'b10, 32'd1);
    directed("seq_chunk0", 32'h1234_5678, 32'h1234_5679, 2'b10, 32'd0);

    // Backpressure: result held while out_ready is low, in_valid ignored.
    issue(0, 32'h8000_0000, 32'h0000_0001, 2'b00, lat);
    chk("bp.latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = (i % 2 == 0);
      a_s[0]      = $urandom;
      @(negedge clk);
      chk("bp.out_valid", 64'(out_valid[0]), 64'd1);
      chk("bp.busy", 64'(busy[0]), 64'd1);
      chk("bp.in_ready", 64'(in_ready[0]), 64'd0);
      chk("bp.result", 64'(result[0]), 64'd1);
    end
    in_valid[0] = 1'b0;
    drain(0);
    chk("bp.release.out_valid", 64'(out_valid[0]), 64'd0);
    chk("bp.release.in_ready", 64'(in_ready[0]), 64'd1);
    do_op(0, 32'h0000_0005, 32'h0000_0003, 2'b01, res, lat);
    chk("bp.b2b.result", 64'(res), 64'd0);
    chk("bp.b2b.latency", 64'(lat), 64'd4);

    // Leave a nonzero result behind so reset visibly clears it.
    directed("pre_reset", 32'h8000_0000, 32'h0000_0001, 2'b00, 32'd1);

    // Reset while chunk 2 is being processed.
    in_valid[0] = 1'b1;
    a_s[0]      = 32'h0000_0000;
    b_s[0]      = 32'hFFFF_FFFF;
    op_s[0]     = 2'b01;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrun.in_ready", 64'(in_ready[0]), 64'd1);
    chk("midrun.out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrun.busy", 64'(busy[0]), 64'd0);
    chk("midrun.result", 64'(result[0]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stray = stray | out_valid[0] | busy[0];
    end
    chk("midrun.no_result", 64'(stray), 64'd0);
    directed("post_reset_sltu", 32'h0000_0000, 32'h0000_0001, 2'b01, 32'd1);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
